fsk_frame_modulator: RTL and testbench
======================================

// Module: fsk_frame_modulator
// PURPOSE
//  Binary FSK modulator clocked by the on-chip 16 MHz oscillator clock.
//  Accepts bytes over a valid/ready handshake and frames each one as start(0), 8 data LSB-first, stop(1).
//  Each symbol is emitted as a square-wave tone: mark (1) = HALF_MARK-cycle half-period, space (0) = HALF_SPACE.
//  tone_out drives the transmitter's audio/RF output pin; tx_busy gates upstream byte sources.
// PARAMETERS
//  HALF_MARK   4000   clk cycles per tone half-period for a '1' (2 kHz @16 MHz)
//  HALF_SPACE  8000   clk cycles per tone half-period for a '0' (1 kHz @16 MHz)
//  BIT_CYCLES  16000  clk cycles per symbol (1 kbaud @16 MHz)
//  Constraints: HALF_* >= 1; BIT_CYCLES >= 2*max(HALF_MARK,HALF_SPACE); counter widths via $clog2.
// PORTS
//  clk         in   1  16 MHz system clock (oscillator output)
//  reset       in   1  synchronous, active-high reset
//  data_in     in   8  byte to transmit
//  data_valid  in   1  data_in valid
//  data_ready  out  1  block can accept a byte (high only in IDLE)
//  tone_out    out  1  FSK square-wave output
//  bit_out     out  1  symbol currently being sent (debug/monitor)
//  tx_busy     out  1  high from START through end of STOP
// BEHAVIOUR
//  Clocking/reset: one clock domain. reset is sampled on the clk edge.
//  Reset values: state=IDLE, data_ready=1, tone_out=0, bit_out=1, tx_busy=0, all counters=0.
//  Reset mid-frame aborts the frame. IDLE is reached the next cycle; the partial frame is discarded.
//  FSM states and transitions:
//   - IDLE: data_ready=1, tone_out held 0, tone counter held 0. Accept when data_valid&&data_ready on edge N:
//     latch data_in into shift reg; enter START at N+1 with data_ready=0, tx_busy=1.
//   - START: bit_out=0. After BIT_CYCLES cycles, enter DATA with bit index 0.
//   - DATA: bit_out=shreg[idx], LSB first. Each bit lasts BIT_CYCLES cycles. After idx 7, enter STOP.
//   - STOP: bit_out=1 for BIT_CYCLES cycles, then IDLE.
//   - Frame length: exactly 10*BIT_CYCLES cycles; data_ready is high again from cycle N+1+10*BIT_CYCLES.
//  Tone generator:
//   - Half-period select: half = bit_out ? HALF_MARK : HALF_SPACE.
//   - Counter runs 0..half-1. On half-1, tone_out toggles and the counter returns to 0.
//   - Entering START: counter=0, tone_out=0. First toggle is visible at cycle N+1+HALF_SPACE.
//   - Symbol boundary: counter restarts at 0 and tone_out keeps its level (no glitch, no forced phase reset).
//   - Return to IDLE: tone_out=0 and counter=0 on the first IDLE cycle.
//  Bit counter: cycle counter runs 0..BIT_CYCLES-1 and wraps at each symbol boundary. Bit index is 3 bits, 0..7.
//  Handshake edge cases:
//   - data_valid while busy is ignored (no accept, no latch).
//   - data_in may change after acceptance without effect.
//   - Back-to-back bytes: the earliest next accept is the first IDLE cycle. No stop/start merging.
//  No combinational paths from inputs to outputs; all outputs registered.
// TESTING (sim params HALF_MARK=2, HALF_SPACE=4, BIT_CYCLES=16)
//  1. Reset: hold reset 3 cycles, data_valid=1 -> data_ready=1, tone_out=0, tx_busy=0, bit_out=1.
//  2. Send 0xA5 -> bit_out sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_busy high 160 cycles. data_ready returns at N+161.
//  3. Tone check on 0x00 -> start/data symbols toggle every 4 cycles (first toggle at N+5); stop toggles every 2.
//  4. data_valid held high with 0x55 then 0xFF during the frame -> only 0x55 sent. 0xFF is accepted on the first IDLE cycle.
//  5. Assert reset at cycle 70 of a frame -> next cycle IDLE: tone_out=0, tx_busy=0, data_ready=1. The following byte sends a clean frame.
//  6. Send 0x0F -> at the 0->1 boundary tone_out holds its level; the next toggle comes 2 cycles later, with no 1-cycle pulse.

Source files
------------

// File: rtl/fsk_frame_modulator.sv
// Binary FSK byte modulator: frames each accepted byte as start/8 data (LSB first)/stop
// and emits each symbol as a square-wave tone whose half-period is set by the symbol value.
module fsk_frame_modulator #(
  parameter int HALF_MARK  = 4000,
  parameter int HALF_SPACE = 8000,
  parameter int BIT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tone_out,
  output logic       bit_out,
  output logic       tx_busy
);

  localparam int HMAX = (HALF_MARK > HALF_SPACE) ? HALF_MARK : HALF_SPACE;
  localparam int TW   = $clog2(HMAX + 1);
  localparam int BW   = $clog2(BIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      idx_q, idx_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            tone_q, tone_d;
  logic            bit_q, bit_d;

  logic            sym_end;
  logic [TW-1:0]   half_m1;
  logic [2:0]      idx_nxt;

  assign sym_end = (bcnt_q == BW'(BIT_CYCLES - 1));
  assign half_m1 = bit_q ? TW'(HALF_MARK - 1) : TW'(HALF_SPACE - 1);
  assign idx_nxt = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      tone_q  <= 1'b0;
      bit_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    tone_d  = tone_q;
    bit_d   = bit_q;
    if (state_q == S_IDLE) begin
      tcnt_d = '0;
      tone_d = 1'b0;
      bcnt_d = '0;
      idx_d  = '0;
      bit_d  = 1'b1;
      if (data_valid) begin
        shreg_d = data_in;
        state_d = S_START;
        bit_d   = 1'b0;
      end
    end else begin
      bcnt_d = sym_end ? '0 : bcnt_q + 1'b1;
      if (tcnt_q == half_m1) begin
        tone_d = ~tone_q;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      // Symbol boundary restarts the half-period count but never forces the tone level.
      if (sym_end) begin
        tcnt_d = '0;
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            idx_d   = '0;
            bit_d   = shreg_q[0];
          end
          S_DATA: begin
            if (idx_q == 3'd7) begin
              state_d = S_STOP;
              bit_d   = 1'b1;
            end else begin
              idx_d = idx_nxt;
              bit_d = shreg_q[idx_nxt];
            end
          end
          default: begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
            bit_d   = 1'b1;
          end
        endcase
      end
    end
  end

  assign data_ready = (state_q == S_IDLE);
  assign tx_busy    = (state_q != S_IDLE);
  assign tone_out   = tone_q;
  assign bit_out    = bit_q;

endmodule

// File: tb/tb_fsk_frame_modulator.sv
// Self-checking bench: a frame-level reference model predicts every output on every cycle.
module tb_fsk_frame_modulator;
  localparam int HM = 2, HS = 4, BC = 16, FR = 10 * BC;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, tone_out, bit_out, tx_busy;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: busy flag, cycle index within frame (1..FR), latched byte
  bit         mbusy = 1'b0;
  int         mk = 0;
  logic [7:0] mbyte = 8'h00;

  fsk_frame_modulator #(.HALF_MARK(HM), .HALF_SPACE(HS), .BIT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tone_out(tone_out), .bit_out(bit_out), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic sym_val(int s);
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return mbyte[s-1];
  endfunction

  function automatic int half_of(logic b);
    return b ? HM : HS;
  endfunction

  task automatic check_outputs();
    logic eb, et;
    int s, j, lvl;
    if (!mbusy) begin
      eb = 1'b1;
      et = 1'b0;
    end else begin
      s = (mk - 1) / BC;
      j = (mk - 1) % BC;
      eb = sym_val(s);
      lvl = 0;
      for (int p = 0; p < s; p++) lvl ^= (BC / half_of(sym_val(p))) & 1;
      lvl ^= (j / half_of(eb)) & 1;
      et = lvl[0];
    end
    chk("data_ready", data_ready, !mbusy);
    chk("tx_busy", tx_busy, mbusy);
    chk("bit_out", bit_out, eb);
    chk("tone_out", tone_out, et);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) mbusy = 1'b0;
    else if (mbusy) begin
      if (mk == FR) mbusy = 1'b0;
      else mk++;
    end else if (data_valid) begin
      mbusy = 1'b1;
      mk = 1;
      mbyte = data_in;
    end
    #1 check_outputs();
  endtask

  task automatic send(input logic [7:0] b, input int tail);
    data_in = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data_in = $urandom;
    for (int i = 0; i < tail; i++) step();
  endtask

  initial begin
    logic [9:0] a5_seq;
    a5_seq = 10'b1101001010;
    reset = 1'b1;
    data_valid = 1'b1;
    data_in = 8'h3C;
    for (int i = 0; i < 3; i++) step();
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_tone", tone_out, 1'b0);
    chk("rst_bit", bit_out, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    reset = 1'b0;
    data_valid = 1'b0;
    step();

    // 0xA5: explicit symbol sequence and frame length
    data_in = 8'hA5;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int k = 2; k <= FR + 1; k++) begin
      step();
      if (k <= FR && ((k - 1) % BC) == 8) chk("a5_sym", bit_out, a5_seq[(k - 1) / BC]);
      if (k == FR) chk("a5_ready_last", data_ready, 1'b0);
      if (k == FR + 1) chk("a5_ready_back", data_ready, 1'b1);
    end

    send(8'h00, FR + 3);

    // valid held through the frame with changing data
    data_in = 8'h55;
    data_valid = 1'b1;
    step();
    data_in = 8'hFF;
    for (int i = 0; i < FR + 2; i++) step();
    data_valid = 1'b0;
    for (int i = 0; i < FR; i++) step();

    // mid-frame reset, then a clean frame
    send(8'hC3, 69);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    send(8'h96, FR + 2);

    send(8'h0F, FR + 2);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 200; i++) begin
        data_valid = ($urandom_range(0, 3) == 0);
        data_in = $urandom;
        reset = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    reset = 1'b0;
    data_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
